imem_arbiter: RTL

//  Shares the single-ported 64-bit instruction memory between the fetch stage and
//  a debug/program-loader port. Fetch has priority; a starvation counter guarantees
//  the debug port a slot. Memory read latency is 1 cycle; the arbiter tracks the
//  in-flight owner and routes read data back to it. Sits between core and imem.

---
 rtl/imem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates the single-ported instruction memory between fetch and the debug/loader port.
// Fetch has priority; a starvation counter forces a debug slot. Read data returns one cycle later.
module imem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_flush_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rvalid_o,
  output logic [DATA_W-1:0] fetch_data_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_e;

  owner_e             inflight_q, inflight_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic fetch_eff, dbg_eff, dbg_win, fetch_win, wait_full;

  // State registers: owner of the read in flight and debug starvation count
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      inflight_q <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A flushing fetch stage cannot take a grant, which also leaves the slot to debug
  always_comb begin
    fetch_eff = fetch_req_i && !fetch_flush_i && !reset_i;
    dbg_eff   = dbg_req_i && !reset_i;
    wait_full = (wait_cnt_q == CNT_W'(MAX_WAIT));
    dbg_win   = dbg_eff && (!fetch_eff || wait_full);
    fetch_win = fetch_eff && !dbg_win;
  end

  // Next-state and memory-side outputs
  always_comb begin
    inflight_d  = OWN_NONE;
    wait_cnt_d  = '0;
    fetch_gnt_o = 1'b0;
    dbg_gnt_o   = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    if (dbg_win) begin
      dbg_gnt_o  = 1'b1;
      mem_addr_o = dbg_addr_i;
      if (dbg_we_i) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = dbg_wdata_i;
      end else begin
        mem_re_o   = 1'b1;
        inflight_d = OWN_DBG;
      end
    end else if (fetch_win) begin
      fetch_gnt_o = 1'b1;
      mem_re_o    = 1'b1;
      mem_addr_o  = fetch_addr_i;
      inflight_d  = OWN_FETCH;
    end

    if (dbg_req_i && !dbg_win) begin
      wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end
  end

  // Route the returning read word to whoever issued it last cycle
  always_comb begin
    fetch_rvalid_o = !reset_i && (inflight_q == OWN_FETCH) && !fetch_flush_i;
    dbg_rvalid_o   = !reset_i && (inflight_q == OWN_DBG);
    fetch_data_o   = fetch_rvalid_o ? mem_rdata_i : '0;
    dbg_rdata_o    = dbg_rvalid_o ? mem_rdata_i : '0;
  end

endmodule
